// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink
//   Consumer end of the renderer pixel stream. Plot writes (x, y, colour) are
//   range-checked, buffered in a small FIFO and turned into linear framebuffer
//   writes (addr = y*SCREEN_X + x) behind a ready/valid write port. A flush
//   machine reports when every pixel accepted up to frame_end has been written.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   pix_valid/ready    pixel handshake (ready = FIFO not full)
//   pix_x/y/col        pixel coordinates and colour
//   frame_end          pulse: last pixel of the frame has been issued
//   drained            pulse: everything before frame_end has been written
//   fb_we/ready        framebuffer write handshake
//   fb_addr/data       framebuffer write address and colour
//   drop_count         saturating count of out-of-range pixels
//
// Flush FSM states
//   state | meaning
//   IDLE  | no frame pending; frame_end starts a flush
//   FLUSH | waiting for FIFO and output stage to empty, then pulse drained

module pixel_plot_sink #(
    parameter int SCREEN_X   = 640,
    parameter int SCREEN_Y   = 480,
    parameter int COL_W      = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 19,
    localparam int XW        = $clog2(SCREEN_X) + 1,
    localparam int YW        = $clog2(SCREEN_Y) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [XW-1:0]     pix_x,
    input  logic [YW-1:0]     pix_y,
    input  logic [COL_W-1:0]  pix_col,
    input  logic              frame_end,
    output logic              drained,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [COL_W-1:0]  fb_data,
    output logic [7:0]        drop_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = XW + YW + COL_W;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t          state;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            accept;
    logic            in_range;
    logic            push;
    logic            pop;
    logic            out_free;
    logic [XW-1:0]   head_x;
    logic [YW-1:0]   head_y;
    logic [COL_W-1:0] head_col;
    logic [ADDR_W-1:0] head_addr;

    assign pix_ready = (count != CW'(FIFO_DEPTH));
    assign accept    = pix_valid && pix_ready;
    assign in_range  = (pix_x < XW'(SCREEN_X)) && (pix_y < YW'(SCREEN_Y));
    assign push      = accept && in_range;
    assign out_free  = !fb_we || fb_ready;
    assign pop       = out_free && (count != '0);

    assign {head_x, head_y, head_col} = mem[rd_ptr];
    // Widen before multiplying so the product is never truncated.
    assign head_addr = ADDR_W'(head_y) * ADDR_W'(SCREEN_X) + ADDR_W'(head_x);

    // Storage carries no reset; occupancy is governed by count and pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {pix_x, pix_y, pix_col};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else if (pop) begin
            fb_we   <= 1'b1;
            fb_addr <= head_addr;
            fb_data <= head_col;
        end else if (out_free) begin
            fb_we   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_count <= '0;
        else if (accept && !in_range && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
    end

    // A pixel pushed on the completing edge is still part of the frame,
    // so the flush waits for it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            drained <= 1'b0;
        end else begin
            drained <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_end)
                        state <= FLUSH;
                end
                FLUSH: begin
                    if (count == '0 && !push && out_free) begin
                        drained <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_plot_sink.sv
// tb_pixel_plot_sink
//   Directed bench for pixel_plot_sink: reset values, single-pixel latency,
//   backpressure with a full FIFO, out-of-range drops and saturation, flush
//   timing under toggling fb_ready, and asynchronous reset mid-burst.

module tb_pixel_plot_sink;

    logic        clk;
    logic        reset;
    logic        pix_valid;
    logic        pix_ready;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [2:0]  pix_col;
    logic        frame_end;
    logic        drained;
    logic        fb_we;
    logic        fb_ready;
    logic [18:0] fb_addr;
    logic [2:0]  fb_data;
    logic [7:0]  drop_count;

    int n_total = 0;
    int n_pass  = 0;

    pixel_plot_sink dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_col    (pix_col),
        .frame_end  (frame_end),
        .drained    (drained),
        .fb_we      (fb_we),
        .fb_ready   (fb_ready),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_pix(input int x, input int y, input int c);
        pix_valid = 1'b1;
        pix_x     = 11'(x);
        pix_y     = 10'(y);
        pix_col   = 3'(c);
    endtask

    initial begin
        int j;
        int writes;
        int pushed;
        int drain_due;
        int drain_seen;
        int pulses;
        int we_seen;

        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_x     = '0;
        pix_y     = '0;
        pix_col   = '0;
        frame_end = 1'b0;
        fb_ready  = 1'b0;

        // Reset values
        step();
        step();
        chk("rst_fb_we", 32'(fb_we), 0);
        chk("rst_pix_ready", 32'(pix_ready), 1);
        chk("rst_drained", 32'(drained), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_fb_addr", 32'(fb_addr), 0);
        chk("rst_fb_data", 32'(fb_data), 0);
        reset = 1'b0;
        step();

        // Single pixel latency
        fb_ready = 1'b1;
        set_pix(5, 2, 7);
        step();
        pix_valid = 1'b0;
        chk("lat_we_k", 32'(fb_we), 0);
        step();
        chk("lat_we_k1", 32'(fb_we), 1);
        chk("lat_addr", 32'(fb_addr), 1285);
        chk("lat_data", 32'(fb_data), 7);
        step();
        chk("lat_we_off", 32'(fb_we), 0);
        chk("lat_addr_hold", 32'(fb_addr), 1285);

        // Backpressure: 9 pixels fill FIFO plus output register
        fb_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("bp_ready_before", 32'(pix_ready), 1);
            set_pix(i, i + 1, i);
            step();
        end
        pix_valid = 1'b0;
        chk("bp_full_ready", 32'(pix_ready), 0);
        chk("bp_we", 32'(fb_we), 1);
        chk("bp_addr0", 32'(fb_addr), 640);
        step();
        step();
        chk("bp_stall_we", 32'(fb_we), 1);
        chk("bp_stall_addr", 32'(fb_addr), 640);
        fb_ready = 1'b1;
        j = 0;
        for (int cyc = 0; cyc < 30 && j < 9; cyc++) begin
            if (fb_we) begin
                chk("bp_order_addr", 32'(fb_addr), 32'((j + 1) * 640 + j));
                chk("bp_order_data", 32'(fb_data), 32'(j % 8));
                j++;
            end
            step();
        end
        chk("bp_write_count", 32'(j), 9);
        chk("bp_ready_after", 32'(pix_ready), 1);
        chk("bp_we_after", 32'(fb_we), 0);

        // Out-of-range drops and saturation
        set_pix(640, 0, 1);
        step();
        set_pix(0, 480, 1);
        step();
        pix_valid = 1'b0;
        chk("oor_we", 32'(fb_we), 0);
        chk("oor_drop2", 32'(drop_count), 2);
        step();
        chk("oor_we_later", 32'(fb_we), 0);
        set_pix(700, 5, 2);
        for (int i = 0; i < 300; i++)
            step();
        pix_valid = 1'b0;
        chk("oor_sat", 32'(drop_count), 255);
        chk("oor_sat_we", 32'(fb_we), 0);

        // Flush with frame_end on the 4th accept, fb_ready toggling
        pushed     = 0;
        writes     = 0;
        drain_due  = -1;
        drain_seen = -1;
        pulses     = 0;
        for (int c = 0; c < 40; c++) begin
            if (drained) begin
                pulses++;
                if (drain_seen < 0)
                    drain_seen = c;
            end
            if (pushed < 4) begin
                set_pix(10 + pushed, 3, pushed);
                frame_end = (pushed == 3);
                pushed++;
            end else begin
                pix_valid = 1'b0;
                frame_end = 1'b0;
            end
            fb_ready = (c % 2 == 1);
            if (fb_we && fb_ready) begin
                writes++;
                if (writes == 4)
                    drain_due = c + 1;
            end
            step();
        end
        chk("fl_writes", 32'(writes), 4);
        chk("fl_pulses", 32'(pulses), 1);
        chk("fl_when", 32'(drain_seen), 32'(drain_due));

        // frame_end with the sink empty, then a second frame_end in FLUSH
        fb_ready  = 1'b1;
        frame_end = 1'b1;
        step();
        chk("emp_not_yet", 32'(drained), 0);
        step();
        frame_end = 1'b0;
        chk("emp_pulse", 32'(drained), 1);
        step();
        chk("emp_off", 32'(drained), 0);
        step();
        chk("emp_no_second", 32'(drained), 0);

        // Async reset mid-burst with 5 pixels buffered
        fb_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_pix(20 + i, 7, i);
            frame_end = (i == 5);
            step();
        end
        pix_valid = 1'b0;
        frame_end = 1'b0;
        chk("ar_pre_we", 32'(fb_we), 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_we", 32'(fb_we), 0);
        chk("ar_ready", 32'(pix_ready), 1);
        chk("ar_addr", 32'(fb_addr), 0);
        step();
        step();
        reset    = 1'b0;
        fb_ready = 1'b1;
        we_seen  = 0;
        pulses   = 0;
        for (int c = 0; c < 12; c++) begin
            if (fb_we)
                we_seen++;
            if (drained)
                pulses++;
            step();
        end
        chk("ar_no_writes", 32'(we_seen), 0);
        chk("ar_no_drained", 32'(pulses), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
